// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory bus initiator and its bench-side bus monitor.
package mem_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: sequences CPU byte (optionally 16-bit word) requests onto the shared RAM bus.
// Owns bus timing and the direction of mem_data; every output comes straight from a flop.
// Optional feature macro: MEM_BUS_WORD_EN enables two-byte little-endian accesses.
module mem_bus_master
  import mem_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic                  cpu_word,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [2*DATA_W-1:0]   cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic [2*DATA_W-1:0]   cpu_rdata,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_write_enable,
  output logic                  mem_output_enable,
  inout  wire  [DATA_W-1:0]     mem_data
);

`ifdef MEM_BUS_WORD_EN
  localparam int WDATA_W = 2 * DATA_W;
`else
  localparam int WDATA_W = DATA_W;
`endif

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WDATA_W-1:0]    wdata_q, wdata_d;
  logic [ADDR_W-1:0]     bus_addr;
  logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [DATA_W-1:0]     wbyte_q, wbyte_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;

`ifdef MEM_BUS_WORD_EN
  logic                  word_q, word_d;
  logic                  idx_q, idx_d;
`else
  logic [DATA_W:0]       unused_word_inputs;
  assign unused_word_inputs = {cpu_word, cpu_wdata[2*DATA_W-1:DATA_W]};
`endif

  // Next-state logic, plus next values of the registered bus/CPU outputs derived from the next state.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
`ifdef MEM_BUS_WORD_EN
    word_d        = word_q;
    idx_d         = idx_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          write_d = cpu_write;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata[WDATA_W-1:0];
`ifdef MEM_BUS_WORD_EN
          word_d  = cpu_word;
          idx_d   = 1'b0;
`endif
          state_d = cpu_write ? WR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
`ifdef MEM_BUS_WORD_EN
        if (idx_q) begin
          rdata_d[2*DATA_W-1:DATA_W] = mem_data;
        end else begin
          rdata_d = {{DATA_W{1'b0}}, mem_data};
        end
        if (word_q && !idx_q) begin
          idx_d   = 1'b1;
          state_d = RD_ADDR;
        end else begin
          state_d = DONE;
        end
`else
        rdata_d = {{DATA_W{1'b0}}, mem_data};
        state_d = DONE;
`endif
      end
      WR: begin
`ifdef MEM_BUS_WORD_EN
        if (word_q && !idx_q) begin
          idx_d = 1'b1;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MEM_BUS_WORD_EN
    bus_addr = idx_d ? (addr_d + ADDR_W'(1)) : addr_d;
    wbyte_d  = idx_d ? wdata_d[2*DATA_W-1:DATA_W] : wdata_d[DATA_W-1:0];
`else
    bus_addr = addr_d;
    wbyte_d  = wdata_d;
`endif

    mem_address_d = mem_address_q;
    if (state_d == RD_ADDR || state_d == RD_CAP || state_d == WR) begin
      mem_address_d = bus_addr;
    end
    mem_we_d = (state_d == WR);
    mem_oe_d = (state_d == RD_CAP);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // Single register stage for the FSM and all outputs; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_address_q <= '0;
      mem_we_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      wbyte_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
`ifdef MEM_BUS_WORD_EN
      word_q        <= 1'b0;
      idx_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_we_q      <= mem_we_d;
      mem_oe_q      <= mem_oe_d;
      wbyte_q       <= wbyte_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
`ifdef MEM_BUS_WORD_EN
      word_q        <= word_d;
      idx_q         <= idx_d;
`endif
    end
  end

  assign mem_data          = mem_we_q ? wbyte_q : {DATA_W{1'bz}};
  assign mem_address       = mem_address_q;
  assign mem_write_enable  = mem_we_q;
  assign mem_output_enable = mem_oe_q;
  assign cpu_busy          = busy_q;
  assign cpu_done          = done_q;
  assign cpu_rdata         = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: RAM responder, transaction-level expectation queue and per-cycle compare.
// Follows MEM_BUS_WORD_EN the same way the design does.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cpu_req;
  logic                 cpu_write;
  logic                 cpu_word;
  logic [ADDR_W-1:0]    cpu_addr;
  logic [15:0]          cpu_wdata;
  logic                 cpu_busy;
  logic                 cpu_done;
  logic [15:0]          cpu_rdata;
  logic [ADDR_W-1:0]    mem_address;
  logic                 mem_write_enable;
  logic                 mem_output_enable;
  wire  [DATA_W-1:0]    mem_data;

  int checks = 0;
  int errors = 0;

  mem_bus_master dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_req           (cpu_req),
    .cpu_write         (cpu_write),
    .cpu_word          (cpu_word),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_busy          (cpu_busy),
    .cpu_done          (cpu_done),
    .cpu_rdata         (cpu_rdata),
    .mem_address       (mem_address),
    .mem_write_enable  (mem_write_enable),
    .mem_output_enable (mem_output_enable),
    .mem_data          (mem_data)
  );

  always #5 clk = ~clk;

  // RAM responder: writes on a strobed edge, otherwise reloads its read buffer from the current address
  logic [7:0] ram_mem [0:65535];
  logic [7:0] rd_buf;
  logic       fill_ram;

  function automatic logic [7:0] fillByte(input int i);
    logic [15:0] a;
    a = 16'(i);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (fill_ram) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= fillByte(i);
    end else if (mem_write_enable) begin
      ram_mem[mem_address] <= mem_data;
    end else begin
      rd_buf <= ram_mem[mem_address];
    end
  end

  assign mem_data = mem_output_enable ? rd_buf : 8'bzzzzzzzz;

  // Behavioural model: each accepted request expands into a list of expected per-cycle bus records
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        we;
    logic        oe;
    logic        addr_chk;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rd_chk;
    logic [15:0] rdata;
  } rec_t;

  logic [7:0] model_mem [0:65535];
  rec_t       model_q [$];
  rec_t       cur;
  logic       model_ready = 1'b0;
  logic       model_acc = 1'b0;
  logic       held_valid = 1'b0;
  logic [15:0] held_rdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic buildTxn(input logic wr, input logic wd, input logic [15:0] a, input logic [15:0] wdat);
    int          n;
    logic [15:0] ai;
    rec_t        r;
    n = wd ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      ai = a + 16'(i);
      r = '0;
      r.busy = 1'b1;
      r.addr_chk = 1'b1;
      r.addr = ai;
      if (wr) begin
        r.we = 1'b1;
        r.data = (i == 0) ? wdat[7:0] : wdat[15:8];
        model_mem[ai] = r.data;
        model_q.push_back(r);
      end else begin
        model_q.push_back(r);
        r.oe = 1'b1;
        model_q.push_back(r);
      end
    end
    r = '0;
    r.busy = 1'b1;
    r.done = 1'b1;
    if (!wr) begin
      r.rd_chk = 1'b1;
      r.rdata = {(wd ? model_mem[a + 16'd1] : 8'h00), model_mem[a]};
    end
    model_q.push_back(r);
    r = '0;
    model_q.push_back(r);
  endtask

  always @(posedge clk) begin
    rec_t c;
    logic wd;
    model_acc = 1'b0;
`ifdef MEM_BUS_WORD_EN
    wd = cpu_word;
`else
    wd = 1'b0;
`endif
    if (reset) begin
      model_q.delete();
      held_valid = 1'b1;
      held_rdata = '0;
      c = '0;
      c.addr_chk = 1'b1;
      c.rd_chk = 1'b1;
      model_ready = 1'b1;
    end else begin
      if (model_q.size() == 0 && cpu_req) begin
        buildTxn(cpu_write, wd, cpu_addr, cpu_wdata);
        model_acc = 1'b1;
        held_valid = 1'b0;
      end
      if (model_q.size() > 0) c = model_q.pop_front();
      else c = '0;
      if (!c.busy) begin
        c.rd_chk = held_valid;
        c.rdata = held_rdata;
      end else if (c.done && c.rd_chk) begin
        held_valid = 1'b1;
        held_rdata = c.rdata;
      end
    end
    cur = c;
  end

  // Compare process: every cycle, DUT outputs against the model record for that cycle
  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("busy", 32'(cpu_busy), 32'(cur.busy));
      checkOutput("done", 32'(cpu_done), 32'(cur.done));
      checkOutput("write_enable", 32'(mem_write_enable), 32'(cur.we));
      checkOutput("output_enable", 32'(mem_output_enable), 32'(cur.oe));
      checkOutput("we_oe_exclusive", 32'(mem_write_enable & mem_output_enable), 32'd0);
      if (cur.addr_chk) checkOutput("mem_address", 32'(mem_address), 32'(cur.addr));
      if (cur.we) checkOutput("bus_wdata", 32'(mem_data), 32'(cur.data));
      if (cur.rd_chk) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(cur.rdata));
    end
  end

  task automatic applyStimulus(input logic req, input logic wr, input logic wd,
                               input logic [15:0] a, input logic [15:0] wdat);
    cpu_req   = req;
    cpu_write = wr;
    cpu_word  = wd;
    cpu_addr  = a;
    cpu_wdata = wdat;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (model_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitAccept();
    logic acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk);
      #1;
      acc = model_acc;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // One full transaction: returns the done cycle index, rdata at done and the write-strobe count
  task automatic doTrans(input logic wr, input logic wd, input logic [15:0] a, input logic [15:0] wdat,
                         output int lat, output logic [15:0] rd, output int we_cnt);
    @(negedge clk);
    applyStimulus(1'b1, wr, wd, a, wdat);
    waitAccept();
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    we_cnt = int'(mem_write_enable);
    while (!cpu_done && lat < 20) begin
      @(negedge clk);
      lat++;
      we_cnt += int'(mem_write_enable);
    end
    rd = cpu_rdata;
  endtask

  initial begin
    int          lat;
    int          we_cnt;
    int          dones;
    int          second_done;
    logic [15:0] rd;

    for (int i = 0; i < 65536; i++) model_mem[i] = fillByte(i);
    fill_ram = 1'b1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    @(negedge clk);
    fill_ram = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(cpu_busy), 32'd0);
    checkOutput("reset_done", 32'(cpu_done), 32'd0);
    checkOutput("reset_we", 32'(mem_write_enable), 32'd0);
    checkOutput("reset_oe", 32'(mem_output_enable), 32'd0);
    checkOutput("reset_addr", 32'(mem_address), 32'h0000);
    checkOutput("reset_rdata", 32'(cpu_rdata), 32'h0000);
    reset = 1'b0;

    // Byte write then byte read
    doTrans(1'b1, 1'b0, 16'h1234, 16'h005A, lat, rd, we_cnt);
    checkOutput("byte_write_latency", 32'(lat), 32'd2);
    checkOutput("byte_write_strobes", 32'(we_cnt), 32'd1);
    waitIdle();
    doTrans(1'b0, 1'b0, 16'h1234, 16'h0000, lat, rd, we_cnt);
    checkOutput("byte_read_latency", 32'(lat), 32'd3);
    checkOutput("byte_read_data", 32'(rd), 32'h005A);
    waitIdle();

    // Word write/read at 0x0100, then word write across the top of the address space
    doTrans(1'b1, 1'b1, 16'h0100, 16'hBEEF, lat, rd, we_cnt);
    waitIdle();
`ifdef MEM_BUS_WORD_EN
    checkOutput("word_write_latency", 32'(lat), 32'd3);
    checkOutput("ram_0100", 32'(ram_mem[16'h0100]), 32'h00EF);
    checkOutput("ram_0101", 32'(ram_mem[16'h0101]), 32'h00BE);
    doTrans(1'b0, 1'b1, 16'h0100, 16'h0000, lat, rd, we_cnt);
    checkOutput("word_read_latency", 32'(lat), 32'd5);
    checkOutput("word_read_data", 32'(rd), 32'hBEEF);
`else
    checkOutput("word_off_write_latency", 32'(lat), 32'd2);
    checkOutput("ram_0100", 32'(ram_mem[16'h0100]), 32'h00EF);
    checkOutput("ram_0101_untouched", 32'(ram_mem[16'h0101]), 32'h003C);
    doTrans(1'b0, 1'b1, 16'h0100, 16'h0000, lat, rd, we_cnt);
    checkOutput("word_off_read_latency", 32'(lat), 32'd3);
    checkOutput("word_off_read_data", 32'(rd), 32'h00EF);
`endif
    waitIdle();
    doTrans(1'b1, 1'b1, 16'hFFFF, 16'hA55A, lat, rd, we_cnt);
    waitIdle();
    checkOutput("ram_ffff", 32'(ram_mem[16'hFFFF]), 32'h005A);
`ifdef MEM_BUS_WORD_EN
    checkOutput("ram_0000_wrapped", 32'(ram_mem[16'h0000]), 32'h00A5);
`else
    checkOutput("ram_0000_untouched", 32'(ram_mem[16'h0000]), 32'h003C);
`endif

    // cpu_req held across a read for four sampled edges: one transaction only
    waitIdle();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
    waitAccept();
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) cpu_req = 1'b0;
      dones += int'(cpu_done);
    end
    checkOutput("held_req_one_txn", 32'(dones), 32'd1);

    // Held for five sampled edges: the second read is accepted right after DONE + IDLE
    waitIdle();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
    waitAccept();
    dones = 0;
    second_done = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 4) cpu_req = 1'b0;
      if (cpu_done) begin
        dones++;
        if (dones == 2) second_done = i;
      end
    end
    checkOutput("held_req_two_txn", 32'(dones), 32'd2);
    checkOutput("second_done_cycle", 32'(second_done), 32'd6);

    // Reset while the read is in its capture cycle
    waitIdle();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
    waitAccept();
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("rdcap_oe", 32'(mem_output_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(cpu_busy), 32'd0);
    checkOutput("abort_oe", 32'(mem_output_enable), 32'd0);
    checkOutput("abort_we", 32'(mem_write_enable), 32'd0);
    dones = int'(cpu_done);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dones += int'(cpu_done);
    end
    checkOutput("abort_no_done", 32'(dones), 32'd0);
    doTrans(1'b0, 1'b0, 16'h1234, 16'h0000, lat, rd, we_cnt);
    checkOutput("post_abort_latency", 32'(lat), 32'd3);
    checkOutput("post_abort_data", 32'(rd), 32'h005A);
    waitIdle();

    // Random traffic over a small address pool, including both ends of the address space
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a;
      int          sel;
      @(negedge clk);
      sel = $urandom_range(0, 3);
      if (sel == 0) a = 16'hFFFF;
      else if (sel == 1) a = 16'h0000;
      else a = 16'h2000 + 16'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a, 16'($urandom));
    end
    @(negedge clk);
    cpu_req = 1'b0;
    waitIdle();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
